// File: rtl/buzzer_sequencer_if.sv
// Register-port bus shared by the CPU side and the Buzzer side of the sequencer.
// A master drives the write/read strobes and addresses; a slave returns registered read data.
interface buzzer_sequencer_if;
    logic [7:0]  addrIn;
    logic [7:0]  addrOut;
    logic [3:0]  sizeDecode;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    modport master (
        output addrIn,
        output addrOut,
        output sizeDecode,
        output dataIn,
        input  dataOut
    );

    modport slave (
        input  addrIn,
        input  addrOut,
        input  sizeDecode,
        input  dataIn,
        output dataOut
    );
endinterface

// File: rtl/buzzer_sequencer.sv
// Melody sequencer: CPU loads notes and a gap on port cpu, playback drives Buzzer registers on port bz.
// Defining BUZ_SEQ_IRQ_EN adds the irq port, CTRL[6] IRQEN and a sticky STAT[16] done flag.
//
// state   | meaning
// IDLE    | waiting for START with at least one note loaded
// CFG     | write OUTP (output select) to Buzzer
// LD_NOTE | write NOTE of the current entry
// LD_TIME | write TIME (duration) of the current entry
// SETTLE  | two cycles for Buzzer register and readback latency
// PLAY    | poll Buzzer TIME readback until it reaches zero
// GAP     | wait the inter-note gap in ms
// NEXT    | advance, wrap (loop) or finish
module buzzer_sequencer #(
    parameter int DEPTH     = 16,
    parameter int MS_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    buzzer_sequencer_if.slave  cpu,
    buzzer_sequencer_if.master bz,
`ifdef BUZ_SEQ_IRQ_EN
    output logic               irq,
`endif
    output logic               busy
);
    localparam int IW  = $clog2(DEPTH);
    localparam int CW  = IW + 1;
    localparam int MSW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [MSW-1:0] MS_LAST = MSW'(MS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CFG     = 3'd1,
        LD_NOTE = 3'd2,
        LD_TIME = 3'd3,
        SETTLE  = 3'd4,
        PLAY    = 3'd5,
        GAP     = 3'd6,
        NEXT    = 3'd7
    } state_t;

    state_t          state, state_n;
    logic [3:0]      mem_note [DEPTH];
    logic [15:0]     mem_dur  [DEPTH];
    logic [CW-1:0]   count;
    logic [IW-1:0]   play_idx, play_idx_n;
    logic [15:0]     gap, gap_ms;
    logic [MSW-1:0]  ms_cnt;
    logic            settle_cnt;
    logic            loop_en, overflow;
    logic [1:0]      outsel;
    logic            stop_pend, stop_pend_n;
    logic            bz_wr;
    logic [1:0]      bz_word;
    logic [31:0]     bz_data;
    logic            done_evt;
    logic            irqen_rd, done_rd;
    logic [3:0]      cur_note;
    logic [15:0]     cur_dur;
    logic [31:0]     stat, ctrl_rd;

    logic [1:0] wa, ra;
    logic       wr_any, ctrl_wr, gap_wr, push_req, start_req, stop_req, clear_req;
    logic       full, empty;

    assign wa        = cpu.addrIn[1:0];
    assign ra        = cpu.addrOut[1:0];
    assign wr_any    = (cpu.sizeDecode != 4'h0);
    assign ctrl_wr   = wr_any && (wa == 2'd0) && cpu.sizeDecode[0];
    assign gap_wr    = wr_any && (wa == 2'd2);
    assign push_req  = (wa == 2'd1) && (cpu.sizeDecode == 4'hF);
    assign stop_req  = ctrl_wr && cpu.dataIn[1];
    assign start_req = ctrl_wr && cpu.dataIn[0] && !cpu.dataIn[1];
    assign clear_req = ctrl_wr && cpu.dataIn[3] && (state == IDLE);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign cur_note  = mem_note[play_idx];
    assign cur_dur   = mem_dur[play_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            play_idx   <= '0;
            stop_pend  <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            gap        <= '0;
            loop_en    <= 1'b0;
            outsel     <= 2'b00;
            gap_ms     <= '0;
            ms_cnt     <= '0;
            settle_cnt <= 1'b0;
        end else begin
            state     <= state_n;
            play_idx  <= play_idx_n;
            stop_pend <= stop_pend_n;
            if (clear_req) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (push_req) begin
                if (full) overflow <= 1'b1;
                else      count    <= count + 1'b1;
            end
            if (ctrl_wr) begin
                loop_en <= cpu.dataIn[2];
                outsel  <= cpu.dataIn[5:4];
            end
            if (gap_wr && cpu.sizeDecode[0]) gap[7:0]  <= cpu.dataIn[7:0];
            if (gap_wr && cpu.sizeDecode[1]) gap[15:8] <= cpu.dataIn[15:8];
            // Gap timer reloads while outside GAP so it is armed on entry.
            if (state != GAP) begin
                gap_ms <= gap;
                ms_cnt <= MS_LAST;
            end else if (gap_ms != 16'd0) begin
                if (ms_cnt == '0) begin
                    gap_ms <= gap_ms - 1'b1;
                    ms_cnt <= MS_LAST;
                end else begin
                    ms_cnt <= ms_cnt - 1'b1;
                end
            end
            if (state != SETTLE) settle_cnt <= 1'b1;
            else                 settle_cnt <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_req && !full) begin
            mem_note[count[IW-1:0]] <= cpu.dataIn[3:0];
            mem_dur[count[IW-1:0]]  <= cpu.dataIn[31:16];
        end
    end

    always_comb begin
        state_n     = state;
        play_idx_n  = play_idx;
        stop_pend_n = stop_pend;
        bz_wr       = 1'b0;
        bz_word     = 2'd0;
        bz_data     = 32'd0;
        done_evt    = 1'b0;
        if (stop_pend) begin
            bz_wr       = 1'b1;
            bz_word     = 2'd1;
            stop_pend_n = 1'b0;
            state_n     = IDLE;
        end else if (stop_req && (state != IDLE)) begin
            stop_pend_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req && !empty && !clear_req) begin
                        state_n    = CFG;
                        play_idx_n = '0;
                    end
                end
                CFG: begin
                    bz_wr   = 1'b1;
                    bz_word = 2'd2;
                    bz_data = {30'd0, outsel};
                    state_n = LD_NOTE;
                end
                LD_NOTE: begin
                    bz_wr   = 1'b1;
                    bz_word = 2'd0;
                    bz_data = {28'd0, cur_note};
                    state_n = (cur_dur == 16'd0) ? GAP : LD_TIME;
                end
                LD_TIME: begin
                    bz_wr   = 1'b1;
                    bz_word = 2'd1;
                    bz_data = {16'd0, cur_dur};
                    state_n = SETTLE;
                end
                SETTLE: if (!settle_cnt) state_n = PLAY;
                PLAY:   if (bz.dataOut == 32'd0) state_n = GAP;
                GAP:    if (gap_ms == 16'd0) state_n = NEXT;
                NEXT: begin
                    if (({1'b0, play_idx} + 1'b1) < count) begin
                        play_idx_n = play_idx + 1'b1;
                        state_n    = LD_NOTE;
                    end else if (loop_en) begin
                        play_idx_n = '0;
                        state_n    = LD_NOTE;
                    end else begin
                        state_n  = IDLE;
                        done_evt = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bz.sizeDecode = bz_wr ? 4'hF : 4'h0;
    assign bz.addrIn     = {6'd0, bz_word};
    assign bz.dataIn     = bz_data;
    assign bz.addrOut    = 8'd1;

    always_comb begin
        stat        = '0;
        stat[0]     = busy;
        stat[1]     = empty;
        stat[2]     = full;
        stat[3]     = overflow;
        stat[8:4]   = 5'(count);
        stat[12:9]  = 4'(play_idx);
        stat[15:13] = state;
        stat[16]    = done_rd;
    end

    assign ctrl_rd = {25'd0, irqen_rd, outsel, 1'b0, loop_en, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu.dataOut <= '0;
        end else begin
            case (ra)
                2'd0:    cpu.dataOut <= ctrl_rd;
                2'd2:    cpu.dataOut <= {16'd0, gap};
                2'd3:    cpu.dataOut <= stat;
                default: cpu.dataOut <= '0;
            endcase
        end
    end

`ifdef BUZ_SEQ_IRQ_EN
    logic irqen, done;
    logic stat_wr;

    assign stat_wr = (wa == 2'd3) && cpu.sizeDecode[2] && cpu.dataIn[16];

    always_ff @(posedge clk) begin
        if (rst) begin
            irqen <= 1'b0;
            done  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            irq <= done_evt && irqen;
            if (ctrl_wr) irqen <= cpu.dataIn[6];
            if (done_evt)     done <= 1'b1;
            else if (stat_wr) done <= 1'b0;
        end
    end

    assign irqen_rd = irqen;
    assign done_rd  = done;

    logic unused_bits;
    assign unused_bits = ^{cpu.addrIn[7:2], cpu.addrOut[7:2]};
`else
    assign irqen_rd = 1'b0;
    assign done_rd  = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{cpu.addrIn[7:2], cpu.addrOut[7:2], done_evt};
`endif
endmodule

// File: tb/tb_buzzer_sequencer.sv
// Self-checking bench for buzzer_sequencer with a small Buzzer TIME model and a write-sequence reference model.
module tb_buzzer_sequencer;
    localparam int DEPTH = 16;
    localparam int MS    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef BUZ_SEQ_IRQ_EN
    logic irq;
    int   irq_cnt = 0;
`endif

    int checks   = 0;
    int failures = 0;

    buzzer_sequencer_if cpu_if ();
    buzzer_sequencer_if bz_if ();

    buzzer_sequencer #(.DEPTH(DEPTH), .MS_CYCLES(MS)) dut (
        .clk  (clk),
        .rst  (rst),
        .cpu  (cpu_if),
        .bz   (bz_if),
`ifdef BUZ_SEQ_IRQ_EN
        .irq  (irq),
`endif
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Buzzer model: TIME counts down once per ms, readback is registered.
    logic [31:0] bz_time;
    int          bz_tick;
    always @(posedge clk) begin
        if (rst) begin
            bz_time        <= 32'd0;
            bz_tick        <= 0;
            bz_if.dataOut  <= 32'd0;
        end else begin
            bz_if.dataOut <= (bz_if.addrOut == 8'd1) ? bz_time : 32'hDEAD_BEEF;
            if (bz_if.sizeDecode == 4'hF && bz_if.addrIn == 8'd1) begin
                bz_time <= bz_if.dataIn;
                bz_tick <= 0;
            end else if (bz_time != 32'd0) begin
                if (bz_tick == MS - 1) begin
                    bz_tick <= 0;
                    bz_time <= bz_time - 32'd1;
                end else begin
                    bz_tick <= bz_tick + 1;
                end
            end
        end
    end

    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    logic [7:0]  ea[$];
    logic [31:0] ed[$];

    always @(negedge clk) begin
        if (!rst && bz_if.sizeDecode != 4'h0) begin
            checks++;
            if (bz_if.sizeDecode != 4'hF) begin
                failures++;
                $display("FAIL bz_size act=%h exp=f", bz_if.sizeDecode);
            end
            wq_addr.push_back(bz_if.addrIn);
            wq_data.push_back(bz_if.dataIn);
        end
`ifdef BUZ_SEQ_IRQ_EN
        if (irq === 1'b1) irq_cnt++;
`endif
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        @(negedge clk);
        cpu_if.addrIn     = {6'd0, a};
        cpu_if.sizeDecode = s;
        cpu_if.dataIn     = d;
        @(negedge clk);
        cpu_if.sizeDecode = 4'h0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cpu_if.addrOut = {6'd0, a};
        @(posedge clk);
        #1 d = cpu_if.dataOut;
    endtask

    task automatic push(input int note, input int dur);
        bus_wr(2'd1, 4'hF, {dur[15:0], 12'd0, note[3:0]});
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout busy=%b budget=%0d", busy, budget);
        end
    endtask

    task automatic chk_writes(input string name);
        chk({name, "_nwr"}, wq_addr.size(), ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wq_addr.size()) begin
                chk($sformatf("%s_addr%0d", name, i), {24'd0, wq_addr[i]}, {24'd0, ea[i]});
                chk($sformatf("%s_data%0d", name, i), wq_data[i], ed[i]);
            end
        end
    endtask

    function automatic logic [31:0] stat_idle(input int cnt, input int idx, input bit ovf);
        logic [31:0] v;
        v = (32'(cnt) << 4) | (32'(idx) << 9);
        if (cnt == 0)     v = v | 32'h2;
        if (cnt == DEPTH) v = v | 32'h4;
        if (ovf)          v = v | 32'h8;
        return v;
    endfunction

    typedef struct {
        bit          rd;
        logic [1:0]  addr;
        logic [3:0]  size;
        logic [31:0] data;
    } vec_t;

    vec_t vt[18];

    initial begin
        logic [31:0] v;
        int          cyc;
        int          nn;
        int          found;

        cpu_if.addrIn     = 8'd0;
        cpu_if.addrOut    = 8'd0;
        cpu_if.sizeDecode = 4'h0;
        cpu_if.dataIn     = 32'd0;

        vt[0]  = '{1'b1, 2'd3, 4'h0, 32'h0000_0002};
        vt[1]  = '{1'b0, 2'd2, 4'h1, 32'h0000_1234};
        vt[2]  = '{1'b1, 2'd2, 4'h0, 32'h0000_0034};
        vt[3]  = '{1'b0, 2'd2, 4'h2, 32'h0000_AB00};
        vt[4]  = '{1'b1, 2'd2, 4'h0, 32'h0000_AB34};
        vt[5]  = '{1'b0, 2'd1, 4'h3, 32'h0005_0003};
        vt[6]  = '{1'b1, 2'd3, 4'h0, 32'h0000_0002};
        vt[7]  = '{1'b0, 2'd1, 4'hF, 32'h0005_0003};
        vt[8]  = '{1'b1, 2'd3, 4'h0, 32'h0000_0010};
        vt[9]  = '{1'b0, 2'd0, 4'hF, 32'h0000_0024};
        vt[10] = '{1'b1, 2'd0, 4'h0, 32'h0000_0024};
        vt[11] = '{1'b0, 2'd0, 4'h0, 32'h0000_0000};
        vt[12] = '{1'b1, 2'd0, 4'h0, 32'h0000_0024};
        vt[13] = '{1'b0, 2'd0, 4'hF, 32'h0000_0008};
        vt[14] = '{1'b1, 2'd3, 4'h0, 32'h0000_0002};
        vt[15] = '{1'b1, 2'd0, 4'h0, 32'h0000_0000};
        vt[16] = '{1'b0, 2'd2, 4'h3, 32'h0000_0000};
        vt[17] = '{1'b1, 2'd2, 4'h0, 32'h0000_0000};

        repeat (3) @(negedge clk);
        chk("rst_bz_size", {28'd0, bz_if.sizeDecode}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dataout", cpu_if.dataOut, 32'd0);
        chk("rst_bz_addrout", {24'd0, bz_if.addrOut}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (vt[i].rd) begin
                bus_rd(vt[i].addr, v);
                chk($sformatf("vec%0d", i), v, vt[i].data);
            end else begin
                bus_wr(vt[i].addr, vt[i].size, vt[i].data);
            end
        end

        // Basic one-shot
        bus_wr(2'd0, 4'hF, 32'h08);
        push(8, 3);
        push(1, 2);
        bus_wr(2'd2, 4'hF, 32'd1);
        wq_addr.delete(); wq_data.delete();
        bus_wr(2'd0, 4'hF, 32'h11);
        wait_idle(400, cyc);
        ea = '{8'd2, 8'd0, 8'd1, 8'd0, 8'd1};
        ed = '{32'd1, 32'd8, 32'd3, 32'd1, 32'd2};
        chk_writes("oneshot");
        chk("oneshot_dur", {31'd0, (cyc >= 65 && cyc <= 130)}, 32'd1);
        bus_rd(2'd3, v);
        chk("oneshot_stat", v, 32'h0000_0220);

        // Zero duration
        bus_wr(2'd0, 4'hF, 32'h08);
        push(5, 0);
        bus_wr(2'd2, 4'hF, 32'd0);
        wq_addr.delete(); wq_data.delete();
        bus_wr(2'd0, 4'hF, 32'h01);
        wait_idle(20, cyc);
        chk("zero_latency", {31'd0, (cyc <= 5)}, 32'd1);
        ea = '{8'd2, 8'd0};
        ed = '{32'd0, 32'd5};
        chk_writes("zero");

        // Overflow, CLEAR, partial-lane PUSH
        bus_wr(2'd0, 4'hF, 32'h08);
        nn = 0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            push($urandom_range(0, 15), $urandom_range(1, 9));
            if (nn < DEPTH) nn++;
        end
        bus_rd(2'd3, v);
        chk("ovf_stat", v, stat_idle(nn, 0, 1'b1));
        bus_wr(2'd0, 4'hF, 32'h08);
        bus_rd(2'd3, v);
        chk("ovf_clear", v, stat_idle(0, 0, 1'b0));
        bus_wr(2'd1, 4'h3, 32'h0003_0002);
        bus_rd(2'd3, v);
        chk("ovf_partial_push", v, stat_idle(0, 0, 1'b0));

        // Loop then STOP during PLAY
        push(2, 3);
        push(3, 3);
        bus_wr(2'd2, 4'hF, 32'd0);
        wq_addr.delete(); wq_data.delete();
        bus_wr(2'd0, 4'hF, 32'h05);
        found = 0;
        for (int c = 0; c < 3000 && found < 5; c++) begin
            @(negedge clk);
            found = 0;
            foreach (wq_addr[j]) if (wq_addr[j] == 8'd0) found++;
        end
        chk("loop_wraps", {31'd0, (found >= 5)}, 32'd1);
        nn = 0;
        foreach (wq_addr[j]) begin
            if (wq_addr[j] == 8'd0 && nn < 5) begin
                chk($sformatf("loop_note%0d", nn), wq_data[j], (nn % 2 == 0) ? 32'd2 : 32'd3);
                nn++;
            end
        end
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            bus_rd(2'd3, v);
            if (v[15:13] == 3'd5 && bz_time >= 32'd2) found = 1;
        end
        chk("loop_reach_play", found, 32'd1);
        bus_wr(2'd0, 4'hF, 32'h02);
        chk("stop_size", {28'd0, bz_if.sizeDecode}, 32'hF);
        chk("stop_addr", {24'd0, bz_if.addrIn}, 32'd1);
        chk("stop_data", bz_if.dataIn, 32'd0);
        @(negedge clk);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        bus_rd(2'd3, v);
        chk("stop_stat", v & 32'h0000_E001, 32'd0);

        // Reset mid-GAP
        bus_wr(2'd0, 4'hF, 32'h08);
        push(4, 1);
        bus_wr(2'd2, 4'hF, 32'd3);
        bus_wr(2'd0, 4'hF, 32'h01);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            bus_rd(2'd3, v);
            if (v[15:13] == 3'd6) found = 1;
        end
        chk("rstgap_reach_gap", found, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstgap_bz_size", {28'd0, bz_if.sizeDecode}, 32'd0);
        chk("rstgap_busy", {31'd0, busy}, 32'd0);
        chk("rstgap_dataout", cpu_if.dataOut, 32'd0);
        bus_rd(2'd3, v);
        chk("rstgap_stat", v, stat_idle(0, 0, 1'b0));
        bus_rd(2'd2, v);
        chk("rstgap_gap", v, 32'd0);
        wq_addr.delete(); wq_data.delete();
        bus_wr(2'd0, 4'hF, 32'h01);
        repeat (5) @(negedge clk);
        chk("rstgap_start_busy", {31'd0, busy}, 32'd0);
        chk("rstgap_start_nwr", wq_addr.size(), 32'd0);

        // Randomized one-shot playback against the write-sequence model
        for (int it = 0; it < 6; it++) begin
            int n, g, os, note, dur;
            n  = $urandom_range(1, 5);
            g  = $urandom_range(0, 2);
            os = $urandom_range(0, 3);
            bus_wr(2'd0, 4'hF, 32'h08);
            ea.delete(); ed.delete();
            ea.push_back(8'd2); ed.push_back(32'(os));
            for (int k = 0; k < n; k++) begin
                note = $urandom_range(0, 15);
                dur  = $urandom_range(0, 3);
                push(note, dur);
                ea.push_back(8'd0); ed.push_back(32'(note));
                if (dur != 0) begin
                    ea.push_back(8'd1); ed.push_back(32'(dur));
                end
            end
            bus_wr(2'd2, 4'hF, 32'(g));
            wq_addr.delete(); wq_data.delete();
            bus_wr(2'd0, 4'hF, (32'(os) << 4) | 32'h1);
            wait_idle(3000, cyc);
            chk_writes($sformatf("rnd%0d", it));
            bus_rd(2'd3, v);
            chk($sformatf("rnd%0d_stat", it), v, stat_idle(n, n - 1, 1'b0));
        end

`ifdef BUZ_SEQ_IRQ_EN
        bus_wr(2'd0, 4'hF, 32'h08);
        push(6, 1);
        bus_wr(2'd2, 4'hF, 32'd0);
        irq_cnt = 0;
        bus_wr(2'd0, 4'hF, 32'h41);
        wait_idle(400, cyc);
        repeat (3) @(negedge clk);
        chk("irq_count", irq_cnt, 32'd1);
        bus_rd(2'd3, v);
        chk("irq_done_set", {31'd0, v[16]}, 32'd1);
        bus_wr(2'd3, 4'hF, 32'h0001_0000);
        bus_rd(2'd3, v);
        chk("irq_done_clr", {31'd0, v[16]}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
